// File: rtl/control_filtro_pb.sv
// Sequencing controller for a second-order IIR section built on a shared multiply-add datapath.
// Steps the recursion F(K) then the output Y(K) one product per cycle and shifts the F history.
module control_filtro_pb (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       en1,
   output logic       en2,
   output logic       en3,
   output logic       en4,
   output logic [2:0] muxS,
   output logic [1:0] muxC,
   output logic [1:0] muxZ,
   output logic       busy,
   output logic       done,
   output logic       overrun
);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StF1    = 3'd1,
      StF2    = 3'd2,
      StY1    = 3'd3,
      StY2    = 3'd4,
      StY3    = 3'd5,
      StShift = 3'd6,
      StDone  = 3'd7
   } state_e;

   state_e state_q, state_d;
   logic   overrun_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         overrun_q <= 1'b0;
      end else begin
         state_q <= state_d;
         // busy is decoded from state_q, so a start in DONE never counts
         if (start && busy) begin
            overrun_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d = StIdle;
      case (state_q)
         StIdle:  state_d = start ? StF1 : StIdle;
         StF1:    state_d = StF2;
         StF2:    state_d = StY1;
         StY1:    state_d = StY2;
         StY2:    state_d = StY3;
         StY3:    state_d = StShift;
         StShift: state_d = StDone;
         StDone:  state_d = start ? StF1 : StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Moore decode: every output depends on state_q only
   always_comb begin
      en1  = 1'b0;
      en2  = 1'b0;
      en3  = 1'b0;
      en4  = 1'b0;
      muxS = 3'd0;
      muxC = 2'd0;
      muxZ = 2'd0;
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         StF1: begin
            muxS = 3'd2;
            muxC = 2'd0;
            muxZ = 2'd3;
            en2  = 1'b1;
            busy = 1'b1;
         end
         StF2: begin
            muxS = 3'd3;
            muxC = 2'd1;
            muxZ = 2'd1;
            en2  = 1'b1;
            busy = 1'b1;
         end
         StY1: begin
            muxS = 3'd1;
            muxC = 2'd2;
            muxZ = 2'd0;
            en1  = 1'b1;
            busy = 1'b1;
         end
         StY2: begin
            muxS = 3'd2;
            muxC = 2'd3;
            muxZ = 2'd2;
            en1  = 1'b1;
            busy = 1'b1;
         end
         StY3: begin
            muxS = 3'd3;
            muxC = 2'd2;
            muxZ = 2'd2;
            en1  = 1'b1;
            busy = 1'b1;
         end
         StShift: begin
            en3  = 1'b1;
            en4  = 1'b1;
            busy = 1'b1;
         end
         StDone: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign overrun = overrun_q;

endmodule

// File: doc/control_filtro_pb.md
CONTROL_FILTRO_PB -- requirements
Module: control_filtro_pb

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces the reset state immediately.
REQ-004 start  input  1  one-cycle sample strobe; a new UK sample is stable from this cycle until done.
REQ-005 en1, en2, en3, en4  output  1 each  load enables for Y(K), F(K), F(K-1) and F(K-2).
REQ-006 muxS  output  3  operand select: 0=UK, 1=F(K), 2=F(K-1), 3=F(K-2), 4=Y(K).
REQ-007 muxC  output  2  coefficient select: 0=C0 (-a1), 1=C1 (-a2), 2=C2 (b0=b2), 3=C3 (b1).
REQ-008 muxZ  output  2  addend select: 0=zero, 1=F(K), 2=Y(K), 3=UK.
REQ-009 busy  output  1  high while a sample is being processed.
REQ-010 done  output  1  one-cycle pulse; YK holds the new output sample.
REQ-011 overrun  output  1  sticky flag: a start arrived while busy.

Function
REQ-012 The datapath computes resul = dato1*dato2 + dato3; the controller SHALL drive only selects and enables.
REQ-013 The FSM SHALL have states IDLE, F1, F2, Y1, Y2, Y3, SHIFT, DONE, encoded in 3 bits.
REQ-014 In IDLE, start=1 SHALL move the FSM to F1; otherwise it SHALL stay in IDLE.
REQ-015 F1: muxS=2, muxC=0, muxZ=3, en2=1, so that F(K) <= C0*F(K-1) + UK.
REQ-016 F2: muxS=3, muxC=1, muxZ=1, en2=1, so that F(K) <= C1*F(K-2) + F(K).
REQ-017 Y1: muxS=1, muxC=2, muxZ=0, en1=1, so that Y(K) <= C2*F(K).
REQ-018 Y2: muxS=2, muxC=3, muxZ=2, en1=1, so that Y(K) <= C3*F(K-1) + Y(K).
REQ-019 Y3: muxS=3, muxC=2, muxZ=2, en1=1, so that Y(K) <= C2*F(K-2) + Y(K).
REQ-020 SHIFT: en3=1 and en4=1 in the same cycle, so that F(K-1) <= F(K) and F(K-2) <= old F(K-1); muxes are 0.
REQ-021 DONE: done=1 for exactly one cycle; all enables are 0.
REQ-022 From DONE, start=1 SHALL go to F1 (back-to-back sample); otherwise the FSM SHALL go to IDLE.
REQ-023 F1 through SHIFT SHALL each last exactly one cycle with unconditional advance.
REQ-024 Latency: the start edge is cycle 0, F1 is cycle 1, and done is high in cycle 7; the minimum start period is 7 cycles.
REQ-025 In every state not listed above, and in IDLE and DONE, en1..en4 SHALL be 0 and muxS, muxC and muxZ SHALL be 0.
REQ-026 At most one of en1 and en2 SHALL be high in any cycle; en3 and en4 SHALL be high only in SHIFT.
REQ-027 busy SHALL be 1 in F1..SHIFT and 0 in IDLE and DONE.
REQ-028 A start while busy=1 SHALL be ignored (the sequence is not restarted) and SHALL set overrun on the next edge.
REQ-029 overrun SHALL remain set until reset.
REQ-030 A start in DONE SHALL NOT set overrun.
REQ-031 An illegal state encoding SHALL return to IDLE on the next edge.
REQ-032 All outputs SHALL be decoded from registered state only (Moore), with no combinational path from start.

Reset
REQ-033 While reset=1 the state SHALL be IDLE and all outputs SHALL be 0, including overrun.
REQ-034 Reset asserted mid-sequence SHALL abort it with no further enables and no done pulse.
REQ-035 After reset is released, the first start SHALL run a full sequence from F1.

Verification
REQ-036 Single sample: one start pulse -> cycles 1..7 show the REQ-015..021 patterns, done in cycle 7, busy high in cycles 1..6, then IDLE.
REQ-037 Closed loop with the datapath: C0=C1=0, C2=1, C3=2, F registers zero, UK=5 -> YK=5 after the first done; UK=0 on the next sample -> YK=10, and on the one after -> YK=5.
REQ-038 Back-to-back: start in cycle 0 and again in cycle 7 (DONE) -> the second F1 is in cycle 8, done in cycle 14, and overrun stays 0.
REQ-039 Overrun: start in cycle 0 and again in cycle 3 -> the sequence is unchanged, done in cycle 7, and overrun=1 from cycle 4 onward.
REQ-040 Reset in Y2: assert reset -> all outputs drop to 0 immediately and there is no done; the next start gives a full 7-cycle sequence.
REQ-041 Enable exclusivity: over 100 random start patterns -> en1&en2 is never 1, and en3/en4 are high only together, once per sequence.
